// File: rtl/sc2110_serdes_pkg.sv
// Shared constants and types for the SC2110 48-bit LVDS serializer/deserializer pair.
package sc2110_serdes_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 48;
  localparam int unsigned BEATS  = 6;
  localparam int unsigned SLOT_W = 3;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [0:0] {
    ST_TRAIN = 1'b0,
    ST_RUN   = 1'b1
  } tx_state_e;

  // Alignment pattern; all six bytes distinct so the receiver can find byte phase.
  localparam word_t TRAIN_WORD_DEFAULT = 48'hA5_3C_96_0F_F0_5A;

endpackage

// File: rtl/sc2110_tx_fifo.sv
// Synchronous word FIFO feeding the serializer.
// Ports: i_lvds_clk/i_rstn clock and async active-low reset; i_push/i_push_data write side;
// i_pop read side; o_head current first word; o_empty; o_ready registered "not full".
module sc2110_tx_fifo
  import sc2110_serdes_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic  i_lvds_clk,
  input  logic  i_rstn,
  input  logic  i_push,
  input  word_t i_push_data,
  input  logic  i_pop,
  output word_t o_head,
  output logic  o_empty,
  output logic  o_ready
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  word_t          mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  cnt_d;
  logic           push_ok;
  logic           pop_ok;
  logic           full;

  assign full    = (cnt_q == CW'(DEPTH));
  assign o_empty = (cnt_q == '0);
  assign push_ok = i_push && !full;
  assign pop_ok  = i_pop && !o_empty;
  assign o_head  = mem_q[rd_ptr_q];

  // Occupancy after this edge; ready is derived from it so it never over-admits.
  always_comb begin
    cnt_d = cnt_q;
    if (push_ok && !pop_ok)      cnt_d = cnt_q + CW'(1);
    else if (!push_ok && pop_ok) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge i_lvds_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      o_ready  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q   <= cnt_d;
      o_ready <= (cnt_d != CW'(DEPTH));
    end
  end

  // Storage array; contents are meaningless while the occupancy is zero.
  always_ff @(posedge i_lvds_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_push_data;
  end

endmodule

// File: rtl/sc2110_serdes_tx_module.sv
// Byte-parallel LVDS transmit serializer: 48-bit words out as 6 bytes, MSB byte first.
// Ports: i_lvds_clk byte clock; i_rstn async active-low reset; i_data/i_data_valid/o_data_ready
// word input handshake; i_train_req training request level; o_lvds_data byte stream;
// o_word_start byte-0 marker; o_training training-word flag; o_underrun idle-word pulse.
module sc2110_serdes_tx_module
  import sc2110_serdes_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter word_t       TRAIN_WORD   = TRAIN_WORD_DEFAULT,
  parameter int unsigned TRAIN_REPEAT = 16,
  parameter word_t       IDLE_WORD    = '0
) (
  input  logic              i_lvds_clk,
  input  logic              i_rstn,
  input  logic [WORD_W-1:0] i_data,
  input  logic              i_data_valid,
  output logic              o_data_ready,
  input  logic              i_train_req,
  output logic [BYTE_W-1:0] o_lvds_data,
  output logic              o_word_start,
  output logic              o_training,
  output logic              o_underrun
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned SHIFT_W = WORD_W - BYTE_W;

  logic [SLOT_W-1:0]  slot_q;
  logic               load_c;
  tx_state_e          state_q;
  tx_state_e          state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               cnt_done_c;
  logic               send_train_c;
  logic               send_idle_c;
  logic               pop_c;
  word_t              word_c;
  logic [SHIFT_W-1:0] shreg_q;
  word_t              fifo_head;
  logic               fifo_empty;

  assign load_c     = (slot_q == SLOT_W'(BEATS - 1));
  assign cnt_done_c = (cnt_q == CNT_W'(TRAIN_REPEAT));

  sc2110_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_lvds_clk  (i_lvds_clk),
    .i_rstn      (i_rstn),
    .i_push      (i_data_valid && o_data_ready),
    .i_push_data (i_data),
    .i_pop       (pop_c),
    .o_head      (fifo_head),
    .o_empty     (fifo_empty),
    .o_ready     (o_data_ready)
  );

  // Byte slot within the current word; the word boundary is the 5->0 wrap.
  always_ff @(posedge i_lvds_clk or negedge i_rstn) begin
    if (!i_rstn)     slot_q <= SLOT_W'(BEATS - 1);
    else if (load_c) slot_q <= '0;
    else             slot_q <= slot_q + SLOT_W'(1);
  end

  // FSM state register.
  always_ff @(posedge i_lvds_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_TRAIN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state; only word boundaries can change it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (load_c) begin
      case (state_q)
        ST_TRAIN: begin
          if (cnt_done_c && !i_train_req) state_d = ST_RUN;
          else if (!cnt_done_c)           cnt_d   = cnt_q + CNT_W'(1);
        end
        ST_RUN: begin
          if (i_train_req) begin
            state_d = ST_TRAIN;
            cnt_d   = '0;
          end
        end
      endcase
    end
  end

  // Word selection: the word on the wire always belongs to the post-edge state.
  always_comb begin
    send_train_c = 1'b0;
    send_idle_c  = 1'b0;
    pop_c        = 1'b0;
    word_c       = IDLE_WORD;
    if (load_c) begin
      send_train_c = (state_d == ST_TRAIN);
      send_idle_c  = !send_train_c && fifo_empty;
      pop_c        = !send_train_c && !fifo_empty;
      if (send_train_c)     word_c = TRAIN_WORD;
      else if (!fifo_empty) word_c = fifo_head;
    end
  end

  // Output shifter and per-word flags.
  always_ff @(posedge i_lvds_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_lvds_data  <= '0;
      shreg_q      <= '0;
      o_word_start <= 1'b0;
      o_training   <= 1'b1;
      o_underrun   <= 1'b0;
    end else if (load_c) begin
      o_lvds_data  <= word_c[WORD_W-1 -: BYTE_W];
      shreg_q      <= word_c[SHIFT_W-1:0];
      o_word_start <= 1'b1;
      o_training   <= send_train_c;
      o_underrun   <= send_idle_c;
    end else begin
      o_lvds_data  <= shreg_q[SHIFT_W-1 -: BYTE_W];
      shreg_q      <= {shreg_q[SHIFT_W-BYTE_W-1:0], BYTE_W'(0)};
      o_word_start <= 1'b0;
      o_underrun   <= 1'b0;
    end
  end

endmodule
